// File: rtl/fifo_drain.sv
// Read stage that drains a FIFO into a 2-entry skid buffer and presents the
// words on a valid/ready stream, counting every delivered word.
module fifo_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  Read_enable,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  pop_count
);

    // Stream handshake: a word transfers on every rising edge where m_valid and
    // m_ready are both 1; m_valid/m_data only change on an edge and m_data holds
    // while m_valid=1 and m_ready=0.
    logic                  inflight;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] tail;
    logic                  pop;
    logic [2:0]            level;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;

    // Occupancy after this edge, counting the in-flight word as already landed.
    always_comb begin
        level       = 3'd0;
        Read_enable = 1'b0;
        level       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        Read_enable = reset && enable && !empty && (level < 3'd2);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight  <= 1'b0;
            occ       <= 2'd0;
            tail      <= '0;
            m_data    <= '0;
            pop_count <= '0;
        end else begin
            inflight <= Read_enable;
            occ      <= level[1:0];
            if (pop) begin
                pop_count <= pop_count + 1'b1;
            end
            if (inflight) begin
                if (occ == 2'd0 || (occ == 2'd1 && pop)) begin
                    m_data <= data_out;
                end else if (occ == 2'd1) begin
                    tail <= data_out;
                end else begin
                    // occ=2 with a capture only happens together with a pop.
                    m_data <= tail;
                    tail   <= data_out;
                end
            end else if (pop && occ == 2'd2) begin
                m_data <= tail;
            end
        end
    end

endmodule
